plot_scheduler: RTL and testbench
=================================

# plot_scheduler

- Shares the single VGA pixel-write port between the three game-object updaters: ball, paddle and block.
- Arbitrates their redraw requests round-robin.
- For each granted request, erases the object's old rectangle and then draws its new rectangle, one pixel per clock.
- Sits between the game-logic updaters and the VGA adapter (160×120, 3-bit colour).

## Interface
Parameters:
- `NREQ`, 3, number of requesters (0 = ball, 1 = paddle, 2 = block).
- `BG_COLOUR`, 3'b000, colour written during erase.
- `MAX_X`, 159, last visible column.
- `MAX_Y`, 119, last visible row.

Ports (packed buses: requester k occupies slice k):
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  redraw request per requester; level, held until ack.
- `req_newx`  in  8·NREQ  new top-left X.
- `req_newy`  in  7·NREQ  new top-left Y.
- `req_oldx`  in  8·NREQ  old top-left X.
- `req_oldy`  in  7·NREQ  old top-left Y.
- `req_sizex`  in  8·NREQ  width in pixels.
- `req_sizey`  in  7·NREQ  height in pixels.
- `req_colour`  in  3·NREQ  draw colour.
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester.
- `busy`  out  1  high whenever state ≠ IDLE.
- `vga_x`  out  8  pixel X.
- `vga_y`  out  7  pixel Y.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  pixel write strobe.

## Operation
States: IDLE, ERASE, DRAW, DONE.

IDLE:
- If any `req` bit is high, grant the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
- On the grant edge: latch that requester's coordinates, sizes and colour; clear scan counters cx, cy; go to ERASE.
- If `sizex` = 0 or `sizey` = 0, go directly to DONE instead.

ERASE:
- Scan row-major, cx fastest: cx 0..W-1, then cy 0..H-1.
- Pixel = (oldx+cx, oldy+cy), colour `BG_COLOUR`.
- After pixel (W-1, H-1), go to DRAW with counters cleared.

DRAW:
- Same scan at (newx+cx, newy+cy) with the latched colour.
- After the last pixel, go to DONE.

DONE:
- `ack[granted]` = 1 for exactly this cycle.
- `rr_ptr` ← granted+1 mod NREQ.
- Go to IDLE.

Arithmetic and clipping:
- Pixel sums are computed 9 bits (X) and 8 bits (Y), with no wrap.
- If a sum exceeds `MAX_X` or `MAX_Y`, `vga_plot` is 0 for that cycle; the scan still takes the cycle.

Output rules:
- `vga_x`, `vga_y` and `vga_colour` are combinational from the state and counters; the low bits of the sum drive `vga_x`/`vga_y`.
- `vga_plot` = (ERASE or DRAW) and in-bounds.

Requester and timing rules:
- A requester must hold its inputs stable from raising `req` until it sees `ack`, and must drop `req` on the edge where it samples `ack`.
- A `req` still high in the IDLE cycle after DONE is treated as a new request.
- Requests arriving while busy wait; they are never lost, since `req` is a level.

Reset (`resetn` low, any time, including mid-scan):
- State → IDLE; `rr_ptr` → 0; counters → 0.
- `ack` = 0, `busy` = 0, `vga_plot` = 0, `vga_x` = 0, `vga_y` = 0, `vga_colour` = 0.
- A partially drawn object is not completed and no `ack` is issued.

## Timing
- Grant latency: the request is granted on the first edge in IDLE where it is the round-robin winner.
- For a W×H object granted at edge E0:
  - Cycles 1..W·H after E0: erase pixels.
  - Cycles W·H+1..2W·H: draw pixels.
  - Cycle 2W·H+1: `ack`.
  - Cycle 2W·H+2: IDLE. The next grant is at the earliest at the end of this cycle.
- Zero-size object: `ack` in cycle 1 after E0; no `vga_plot`.
- Throughput: one pixel per clock during ERASE and DRAW; no stall input (the VGA adapter accepts one write per clock).

## Configuration
`PLOT_SCHED_ERASE_EN`:
- Defined: ERASE state present, as described above.
- Undefined: ERASE state is omitted.
  - IDLE goes directly to DRAW.
  - Old coordinates are ignored (ports remain, unused).
  - Latency becomes W·H+1 cycles to `ack`.

## Test plan
- Single request: ball, old (10,20), new (11,21), 2×2, colour 3'b111. Expect:
  - 4 BG writes (10,20), (11,20), (10,21), (11,21);
  - then 4 writes of colour 7 at (11,21)…(12,22);
  - `ack[0]` in cycle 9;
  - `busy` low in cycle 10.
- Round-robin: all three `req` high, requesters drop `req` on `ack`. Expect grant order 0, 1, 2. Then with `req[0]` and `req[2]` re-raised and `rr_ptr` = 0, expect 0 then 2.
- Clipping: paddle new (150,118), 16×2. Expect:
  - `vga_plot` high only for x ≤ 159, y ≤ 119 (10×2 = 20 draw pixels);
  - 32 draw cycles in total;
  - `ack` at the expected count.
- Zero size: sizex = 0. Expect `ack` in cycle 1 after grant, no `vga_plot`, `rr_ptr` advances.
- Reset mid-scan: assert `resetn` low during DRAW pixel 3. Expect:
  - all outputs 0 immediately (asynchronous);
  - no `ack`;
  - after release, with `req[1]` still high, a fresh full erase+draw for requester 1.
- Macro off: with `PLOT_SCHED_ERASE_EN` undefined, the 2×2 ball case gives 4 draw writes and `ack` in cycle 5.

Source files
------------

// File: rtl/plot_scheduler.sv
// Round-robin arbiter sharing one VGA pixel-write port between NREQ object updaters.
// Define PLOT_SCHED_ERASE_EN to erase each object's old rectangle before drawing the new one.
module plot_scheduler #(
    parameter int         NREQ      = 3,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         MAX_X     = 159,
    parameter int         MAX_Y     = 119
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_newx,
    input  logic [7*NREQ-1:0] req_newy,
    input  logic [8*NREQ-1:0] req_oldx,
    input  logic [7*NREQ-1:0] req_oldy,
    input  logic [8*NREQ-1:0] req_sizex,
    input  logic [7*NREQ-1:0] req_sizey,
    input  logic [3*NREQ-1:0] req_colour,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef PLOT_SCHED_ERASE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd2, DONE = 2'd3} state_t;
`endif

    state_t          state, stateNext;
    logic [PW-1:0]   rrPtr, granted, grantIdx;
    logic            grantFound;
    logic [7:0]      cx, cxNext;
    logic [6:0]      cy, cyNext;
    logic [7:0]      newX, sizeX;
    logic [6:0]      newY, sizeY;
    logic [2:0]      colour;
    logic [7:0]      selSizeX;
    logic [6:0]      selSizeY;
    logic [7:0]      baseX;
    logic [6:0]      baseY;
    logic [8:0]      sumX;
    logic [7:0]      sumY;
    logic            scanning, inBounds, lastCol, lastRow;

    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Lowest offset from rrPtr wins, so iterate from the far end and let nearer hits overwrite.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrapIdx(rrPtr, i)]) begin
                grantFound = 1'b1;
                grantIdx   = wrapIdx(rrPtr, i);
            end
        end
    end

    assign selSizeX = req_sizex[8*int'(grantIdx) +: 8];
    assign selSizeY = req_sizey[7*int'(grantIdx) +: 7];

`ifdef PLOT_SCHED_ERASE_EN
    logic [7:0] oldX;
    logic [6:0] oldY;
    always_ff @(posedge clk) begin
        if (state == IDLE && grantFound) begin
            oldX <= req_oldx[8*int'(grantIdx) +: 8];
            oldY <= req_oldy[7*int'(grantIdx) +: 7];
        end
    end
    assign baseX = (state == DRAW) ? newX : oldX;
    assign baseY = (state == DRAW) ? newY : oldY;
`else
    logic unusedOld;
    assign unusedOld = ^{req_oldx, req_oldy};
    assign baseX = newX;
    assign baseY = newY;
`endif

    always_ff @(posedge clk) begin
        if (state == IDLE && grantFound) begin
            newX   <= req_newx[8*int'(grantIdx) +: 8];
            newY   <= req_newy[7*int'(grantIdx) +: 7];
            sizeX  <= selSizeX;
            sizeY  <= selSizeY;
            colour <= req_colour[3*int'(grantIdx) +: 3];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rrPtr   <= '0;
            granted <= '0;
            cx      <= '0;
            cy      <= '0;
        end else begin
            state <= stateNext;
            cx    <= cxNext;
            cy    <= cyNext;
            if (state == IDLE && grantFound) granted <= grantIdx;
            if (state == DONE) rrPtr <= (granted == PW'(NREQ - 1)) ? '0 : granted + 1'b1;
        end
    end

    // Sums are one bit wider than the screen coordinates so off-screen pixels never wrap back on.
    assign sumX     = {1'b0, baseX} + {1'b0, cx};
    assign sumY     = {1'b0, baseY} + {1'b0, cy};
    assign inBounds = (sumX <= 9'(MAX_X)) && (sumY <= 8'(MAX_Y));
    assign lastCol  = (cx == sizeX - 8'd1);
    assign lastRow  = (cy == sizeY - 7'd1);

    always_comb begin
        stateNext = state;
        cxNext    = cx;
        cyNext    = cy;
        ack       = '0;
        scanning  = 1'b0;
        case (state)
            IDLE: begin
                if (grantFound) begin
                    cxNext = '0;
                    cyNext = '0;
                    if (selSizeX == 8'd0 || selSizeY == 7'd0) stateNext = DONE;
`ifdef PLOT_SCHED_ERASE_EN
                    else stateNext = ERASE;
`else
                    else stateNext = DRAW;
`endif
                end
            end
`ifdef PLOT_SCHED_ERASE_EN
            ERASE,
`endif
            DRAW: begin
                scanning = 1'b1;
                if (lastCol) begin
                    cxNext = '0;
                    if (lastRow) begin
                        cyNext    = '0;
                        stateNext = (state == DRAW) ? DONE : DRAW;
                    end else begin
                        cyNext = cy + 7'd1;
                    end
                end else begin
                    cxNext = cx + 8'd1;
                end
            end
            DONE: begin
                ack[granted] = 1'b1;
                stateNext    = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign vga_plot   = scanning && inBounds;
    assign vga_x      = scanning ? sumX[7:0] : 8'd0;
    assign vga_y      = scanning ? sumY[6:0] : 7'd0;
    assign vga_colour = !scanning ? 3'b000 : (state == DRAW) ? colour : BG_COLOUR;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: pixel scoreboard plus ack timing and arbitration order.
// Expectations follow PLOT_SCHED_ERASE_EN the same way the design does.
module tb_plot_scheduler;

`ifdef PLOT_SCHED_ERASE_EN
    localparam int ERASE_ON = 1;
`else
    localparam int ERASE_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [23:0] newx, oldx, sizex;
    logic [20:0] newy, oldy, sizey;
    logic [8:0]  colour;
    logic [2:0]  ack;
    logic        busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int nTests = 0;
    int nFail  = 0;
    int plotCount = 0;
    logic [17:0] expQ[$];

    plot_scheduler dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_newx(newx), .req_newy(newy), .req_oldx(oldx), .req_oldy(oldy),
        .req_sizex(sizex), .req_sizey(sizey), .req_colour(colour),
        .ack(ack), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel monitor: every write strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (vga_plot === 1'b1) begin
            plotCount++;
            if (expQ.size() == 0) begin
                check("unexpected_plot", {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
            end else begin
                check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, expQ.pop_front()});
            end
        end
    end

    function automatic int lat(input int w, input int h);
        if (w == 0 || h == 0) return 1;
        return (ERASE_ON != 0) ? 2*w*h + 1 : w*h + 1;
    endfunction

    task automatic setObj(input int k, input int ox, input int oy, input int nx, input int ny,
                          input int sx, input int sy, input int col);
        oldx[k*8 +: 8]  = 8'(ox);
        oldy[k*7 +: 7]  = 7'(oy);
        newx[k*8 +: 8]  = 8'(nx);
        newy[k*7 +: 7]  = 7'(ny);
        sizex[k*8 +: 8] = 8'(sx);
        sizey[k*7 +: 7] = 7'(sy);
        colour[k*3 +: 3] = 3'(col);
    endtask

    task automatic pushObj(input int ox, input int oy, input int nx, input int ny,
                           input int sx, input int sy, input int col);
        if (sx == 0 || sy == 0) return;
        if (ERASE_ON != 0) begin
            for (int y = 0; y < sy; y++)
                for (int x = 0; x < sx; x++)
                    if (ox + x <= 159 && oy + y <= 119)
                        expQ.push_back({8'(ox + x), 7'(oy + y), 3'b000});
        end
        for (int y = 0; y < sy; y++)
            for (int x = 0; x < sx; x++)
                if (nx + x <= 159 && ny + y <= 119)
                    expQ.push_back({8'(nx + x), 7'(ny + y), 3'(col)});
    endtask

    task automatic waitAck(input int k, input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (ack[k] === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic waitAnyAck(input int limit, output int idx, output int cyc);
        idx = -1;
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (ack !== 3'b000) begin
                cyc = c;
                for (int k = 0; k < 3; k++) if (ack[k] === 1'b1) idx = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc, idx, base;
        resetn = 1'b0;
        req = '0; newx = '0; oldx = '0; sizex = '0;
        newy = '0; oldy = '0; sizey = '0; colour = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {29'd0, ack}, 32'd0);
        check("rst_plot", {31'd0, vga_plot}, 32'd0);
        check("rst_xyc", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single 2x2 ball request
        setObj(0, 10, 20, 11, 21, 2, 2, 7);
        pushObj(10, 20, 11, 21, 2, 2, 7);
        base = plotCount;
        req[0] = 1'b1;
        waitAck(0, 40, cyc);
        check("t1_ack_cycle", cyc, lat(2, 2));
        check("t1_ack_onehot", {29'd0, ack}, 32'd1);
        check("t1_busy_at_ack", {31'd0, busy}, 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        check("t1_plots", plotCount - base, 4 * (1 + ERASE_ON));
        check("t1_queue_empty", expQ.size(), 0);

        // Zero-size paddle, then the advanced pointer must favour requester 2
        setObj(1, 0, 0, 40, 40, 0, 2, 5);
        base = plotCount;
        req[1] = 1'b1;
        waitAck(1, 10, cyc);
        check("zs_ack_cycle", cyc, 1);
        req[1] = 1'b0;
        check("zs_no_plot", plotCount - base, 0);
        @(negedge clk);
        setObj(0, 50, 50, 51, 51, 1, 1, 3);
        setObj(2, 60, 60, 61, 61, 1, 1, 4);
        pushObj(60, 60, 61, 61, 1, 1, 4);
        pushObj(50, 50, 51, 51, 1, 1, 3);
        req[0] = 1'b1;
        req[2] = 1'b1;
        waitAnyAck(20, idx, cyc);
        check("zs_rr_first", idx, 2);
        check("zs_rr_first_cyc", cyc, lat(1, 1));
        if (idx >= 0) req[idx] = 1'b0;
        waitAnyAck(20, idx, cyc);
        check("zs_rr_second", idx, 0);
        check("zs_rr_second_cyc", cyc, 1 + lat(1, 1));
        if (idx >= 0) req[idx] = 1'b0;
        check("zs_queue_empty", expQ.size(), 0);

        // Round-robin from a fresh pointer: all three, then 0 and 2
        req = '0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setObj(k, k*10, 5, k*10 + 1, 6, 1, 1, k + 1);
            pushObj(k*10, 5, k*10 + 1, 6, 1, 1, k + 1);
        end
        req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            waitAnyAck(20, idx, cyc);
            check("rr_order", idx, k);
            check("rr_cycle", cyc, (k == 0) ? lat(1, 1) : 1 + lat(1, 1));
            if (idx >= 0) req[idx] = 1'b0;
        end
        @(negedge clk);
        pushObj(0, 5, 1, 6, 1, 1, 1);
        pushObj(20, 5, 21, 6, 1, 1, 3);
        req[0] = 1'b1;
        req[2] = 1'b1;
        waitAnyAck(20, idx, cyc);
        check("rr2_first", idx, 0);
        if (idx >= 0) req[idx] = 1'b0;
        waitAnyAck(20, idx, cyc);
        check("rr2_second", idx, 2);
        if (idx >= 0) req[idx] = 1'b0;
        check("rr_queue_empty", expQ.size(), 0);

        // Clipping: 16x2 paddle at the bottom-right corner
        @(negedge clk);
        setObj(1, 149, 118, 150, 118, 16, 2, 3);
        pushObj(149, 118, 150, 118, 16, 2, 3);
        base = plotCount;
        req[1] = 1'b1;
        waitAck(1, 100, cyc);
        check("clip_ack_cycle", cyc, lat(16, 2));
        req[1] = 1'b0;
        check("clip_plots", plotCount - base, 20 + ERASE_ON * 22);
        check("clip_queue_empty", expQ.size(), 0);

        // Reset during the third draw pixel, then a full redo for requester 1
        @(negedge clk);
        setObj(1, 30, 40, 31, 40, 2, 2, 2);
        pushObj(30, 40, 31, 40, 2, 2, 2);
        req[1] = 1'b1;
        repeat (ERASE_ON * 4 + 3) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_plot", {31'd0, vga_plot}, 32'd0);
        check("mid_rst_xyc", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        check("mid_rst_ack", {29'd0, ack}, 32'd0);
        expQ.delete();
        @(negedge clk);
        check("mid_rst_ack_hold", {29'd0, ack}, 32'd0);
        #1 resetn = 1'b1;
        pushObj(30, 40, 31, 40, 2, 2, 2);
        base = plotCount;
        waitAck(1, 40, cyc);
        check("mid_rst_redo_cycle", cyc, lat(2, 2));
        req[1] = 1'b0;
        check("mid_rst_redo_plots", plotCount - base, 4 * (1 + ERASE_ON));
        check("mid_rst_queue_empty", expQ.size(), 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
